// File: rtl/regfile_dumper_pkg.sv
// Shared register-file dimensions and dump FSM state type.
package regfile_dump_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    HOLD,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dumper_if.sv
// Valid/ready word stream carrying (index, value) pairs out of the dumper.
interface regfile_dumper_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    output out_ready
  );

endinterface

// File: rtl/regfile_dumper.sv
// Walks the register file read port from FIRST_REG to LAST_REG and streams
// each (index, value) pair over a valid/ready handshake.
module regfile_dumper
  import regfile_dump_pkg::*;
#(
  parameter int unsigned DATA_W    = regfile_dump_pkg::DATA_W,
  parameter int unsigned ADDR_W    = regfile_dump_pkg::ADDR_W,
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   readaddr,
  input  logic [DATA_W-1:0]   readdata,
  regfile_dumper_if.master    stream,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

  dump_state_t       state;
  dump_state_t       state_d;
  logic [ADDR_W-1:0] readaddr_d;
  logic [ADDR_W-1:0] index_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;
  logic              busy_d;
  logic              done_d;

  // State and every output are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      readaddr         <= '0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_index <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state            <= state_d;
      readaddr         <= readaddr_d;
      stream.out_valid <= valid_d;
      stream.out_data  <= data_d;
      stream.out_index <= index_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

  // Next-state and next-output logic; done is a pulse so it defaults low.
  always_comb begin
    state_d    = state;
    readaddr_d = readaddr;
    data_d     = stream.out_data;
    index_d    = stream.out_index;
    valid_d    = stream.out_valid;
    busy_d     = busy;
    done_d     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d    = READ;
          readaddr_d = FIRST_A;
          busy_d     = 1'b1;
        end
      end

      READ: begin
        // Read data is combinational (including write bypass), so capture now.
        data_d  = readdata;
        index_d = readaddr;
        valid_d = 1'b1;
        state_d = HOLD;
      end

      HOLD: begin
        if (stream.out_valid && stream.out_ready) begin
          valid_d = 1'b0;
          if (stream.out_index == LAST_A) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            readaddr_d = readaddr + ADDR_W'(1);
            state_d    = READ;
          end
        end
      end

      DONE: begin
        busy_d     = 1'b0;
        readaddr_d = '0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Self-checking bench: a register-file model feeds two dumpers (full range on
// read port 2, single register 6 on read port 1); accepted words are scoreboarded.
module tb_regfile_dumper;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst       = 1'b1;
  logic          start     = 1'b0;
  logic          start6    = 1'b0;
  logic          we        = 1'b0;
  logic [AW-1:0] writeaddr = '0;
  logic [DW-1:0] writedata = '0;
  logic [AW-1:0] readaddr1, readaddr2;
  logic [DW-1:0] readdata1, readdata2;
  logic          busy, done, busy6, done6;

  regfile_dumper_if #(.DATA_W(DW), .ADDR_W(AW)) bus  ();
  regfile_dumper_if #(.DATA_W(DW), .ADDR_W(AW)) bus6 ();

  regfile_dumper #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .readaddr (readaddr2),
    .readdata (readdata2),
    .stream   (bus),
    .busy     (busy),
    .done     (done)
  );

  regfile_dumper #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(6), .LAST_REG(6)) u_dut6 (
    .clk      (clk),
    .rst      (rst),
    .start    (start6),
    .readaddr (readaddr1),
    .readdata (readdata1),
    .stream   (bus6),
    .busy     (busy6),
    .done     (done6)
  );

  // Register file: reg 0 hardwired to zero, combinational read with write bypass.
  logic [DW-1:0] mem [32];
  always_ff @(posedge clk) if (we && writeaddr != '0) mem[writeaddr] <= writedata;
  assign readdata1 = (readaddr1 == '0) ? '0 : (we && writeaddr == readaddr1) ? writedata : mem[readaddr1];
  assign readdata2 = (readaddr2 == '0) ? '0 : (we && writeaddr == readaddr2) ? writedata : mem[readaddr2];

  logic [DW-1:0] ref_mem [32];
  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard capture: a word counts when valid && ready just before an edge.
  int            acc_idx  [$];
  logic [DW-1:0] acc_data [$];
  int            acc_cyc  [$];
  int            acc6_idx [$];
  logic [DW-1:0] acc6_data[$];
  int done_cnt  = 0;
  int done_cyc  = 0;
  int done6_cnt = 0;
  int busy6_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        acc_idx.push_back(int'(bus.out_index));
        acc_data.push_back(bus.out_data);
        acc_cyc.push_back(cyc);
      end
      if (bus6.out_valid && bus6.out_ready) begin
        acc6_idx.push_back(int'(bus6.out_index));
        acc6_data.push_back(bus6.out_data);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done6) done6_cnt++;
      if (busy6) busy6_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
      if (rnd) bus.out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.out_ready = 1'b1;
  endtask

  // Wait for the READ cycle of register a on the full-range dumper.
  task automatic wait_read(input int a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy && !bus.out_valid && int'(readaddr2) == a) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (readaddr2 !== '0) begin failures++; $display("FAIL reset_readaddr got=%0d exp=0", readaddr2); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_index !== '0) begin failures++; $display("FAIL reset_index got=%0d exp=0", bus.out_index); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start got=%b exp=0", busy); end
  endtask

  task automatic preload();
    ref_mem[0] = '0;
    for (int k = 1; k < 32; k++) begin
      ref_mem[k] = 32'(k) * 32'h01010101;
      we = 1'b1; writeaddr = AW'(k); writedata = ref_mem[k];
      step();
    end
    we = 1'b0;
    step();
  endtask

  task automatic test_full_dump();
    int base_n, base_d, s_cyc, n;
    bit ok;
    base_n = acc_idx.size(); base_d = done_cnt;
    bus.out_ready = 1'b1;
    s_cyc = cyc + 1;
    pulse_start();
    wait_done(base_d, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL full_timeout got=none exp=done"); end
    step();
    n = acc_idx.size() - base_n;
    checks++; if (n != 32) begin failures++; $display("FAIL full_count got=%0d exp=32", n); end
    for (int i = 0; i < n && i < 32; i++) begin
      checks++; if (acc_idx[base_n+i] != i || acc_data[base_n+i] !== ref_mem[i]) begin
        failures++; $display("FAIL full_word[%0d] got=%0d:%h exp=%0d:%h", i, acc_idx[base_n+i], acc_data[base_n+i], i, ref_mem[i]);
      end
    end
    if (n >= 32) begin
      checks++; if (acc_data[base_n] !== 32'h0) begin failures++; $display("FAIL full_reg0 got=%h exp=0", acc_data[base_n]); end
      checks++; if (acc_data[base_n+31] !== 32'h1F1F1F1F) begin failures++; $display("FAIL full_reg31 got=%h exp=1f1f1f1f", acc_data[base_n+31]); end
    end
    checks++; if (done_cnt - base_d != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_cnt - base_d); end
    // done is seen 64 edges after the edge that accepts start (cycle 65).
    checks++; if (done_cyc - s_cyc != 64) begin failures++; $display("FAIL full_latency got=%0d exp=64", done_cyc - s_cyc); end
  endtask

  task automatic test_backpressure();
    int base_n, base_d, p6, p7;
    bit ok;
    base_n = acc_idx.size(); base_d = done_cnt;
    bus.out_ready = 1'b1;
    pulse_start();
    wait_read(6, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_reach6 got=none exp=read6"); end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== AW'(6) || bus.out_data !== 32'h06060606 || readaddr2 !== AW'(6)) begin
        failures++; $display("FAIL bp_hold[%0d] got=v%b i%0d d%h a%0d exp=v1 i6 d06060606 a6", i, bus.out_valid, bus.out_index, bus.out_data, readaddr2);
      end
    end
    bus.out_ready = 1'b1;
    wait_done(base_d, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=none exp=done"); end
    step();
    p6 = -1; p7 = -1;
    for (int i = base_n; i < acc_idx.size(); i++) begin
      if (acc_idx[i] == 6) p6 = i;
      if (acc_idx[i] == 7) p7 = i;
    end
    checks++; if (p6 < 0 || p7 < 0 || acc_cyc[p7] - acc_cyc[p6] != 2) begin
      failures++; $display("FAIL bp_next_gap got=%0d exp=2", (p6 < 0 || p7 < 0) ? -1 : acc_cyc[p7] - acc_cyc[p6]);
    end
    checks++; if (acc_idx.size() - base_n != 32) begin failures++; $display("FAIL bp_count got=%0d exp=32", acc_idx.size() - base_n); end
  endtask

  task automatic test_mid_start();
    int base_n, base_d, busy_low, n;
    bit injected, finished;
    base_n = acc_idx.size(); base_d = done_cnt;
    busy_low = 0; injected = 1'b0; finished = 1'b0;
    bus.out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (done_cnt > base_d) begin
        finished = 1'b1;
        break;
      end
      if (!busy) busy_low++;
      if (!injected && int'(readaddr2) == 10) begin
        start = 1'b1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n = acc_idx.size() - base_n;
    checks++; if (!finished) begin failures++; $display("FAIL mid_timeout got=none exp=done"); end
    checks++; if (busy_low != 0) begin failures++; $display("FAIL mid_busy_gap got=%0d exp=0", busy_low); end
    checks++; if (n != 32) begin failures++; $display("FAIL mid_count got=%0d exp=32", n); end
    for (int i = 0; i < n && i < 32; i++) begin
      checks++; if (acc_idx[base_n+i] != i) begin failures++; $display("FAIL mid_idx[%0d] got=%0d exp=%0d", i, acc_idx[base_n+i], i); end
    end
    checks++; if (done_cnt - base_d != 1) begin failures++; $display("FAIL mid_done_count got=%0d exp=1", done_cnt - base_d); end
  endtask

  task automatic test_reset_mid();
    int base_n, base_d;
    bit ok;
    base_d = done_cnt;
    bus.out_ready = 1'b1;
    pulse_start();
    wait_read(12, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_reach12 got=none exp=read12"); end
    bus.out_ready = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_index !== AW'(12)) begin failures++; $display("FAIL rstmid_hold got=v%b i%0d exp=v1 i12", bus.out_valid, bus.out_index); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || readaddr2 !== '0 || done !== 1'b0) begin
      failures++; $display("FAIL rstmid_state got=v%b b%b a%0d d%b exp=v0 b0 a0 d0", bus.out_valid, busy, readaddr2, done);
    end
    checks++; if (bus.out_index !== '0 || bus.out_data !== '0) begin failures++; $display("FAIL rstmid_payload got=%0d:%h exp=0:0", bus.out_index, bus.out_data); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++; if (done_cnt != base_d || busy !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%0d/b%b exp=0/b0", done_cnt - base_d, busy); end
    base_n = acc_idx.size();
    pulse_start();
    wait_done(base_d, 1'b0, ok);
    step();
    checks++; if (!ok || acc_idx.size() - base_n != 32) begin failures++; $display("FAIL rstmid_restart_count got=%0d exp=32", acc_idx.size() - base_n); end
    checks++; if (acc_idx.size() == base_n || acc_idx[base_n] != 0) begin failures++; $display("FAIL rstmid_restart_first got=%0d exp=0", (acc_idx.size() == base_n) ? -1 : acc_idx[base_n]); end
  endtask

  task automatic test_single_reg();
    int base_n, base_d, base_b;
    bit ok;
    base_n = acc6_idx.size(); base_d = done6_cnt; base_b = busy6_cnt;
    bus6.out_ready = 1'b1;
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done6_cnt > base_d) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    for (int i = 0; i < 4; i++) step();
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=none exp=done"); end
    checks++; if (acc6_idx.size() - base_n != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", acc6_idx.size() - base_n); end
    if (acc6_idx.size() > base_n) begin
      checks++; if (acc6_idx[base_n] != 6 || acc6_data[base_n] !== 32'h06060606) begin
        failures++; $display("FAIL single_word got=%0d:%h exp=6:06060606", acc6_idx[base_n], acc6_data[base_n]);
      end
    end
    checks++; if (busy6_cnt - base_b != 3) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=3", busy6_cnt - base_b); end
    checks++; if (done6_cnt - base_d != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done6_cnt - base_d); end
  endtask

  task automatic test_bypass();
    int base_n, base_d, p5;
    bit ok;
    base_n = acc_idx.size(); base_d = done_cnt;
    bus.out_ready = 1'b1;
    pulse_start();
    wait_read(5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bypass_reach5 got=none exp=read5"); end
    we = 1'b1; writeaddr = AW'(5); writedata = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    step();
    we = 1'b0;
    wait_done(base_d, 1'b0, ok);
    step();
    p5 = -1;
    for (int i = base_n; i < acc_idx.size(); i++) if (acc_idx[i] == 5) p5 = i;
    checks++; if (p5 < 0 || acc_data[p5] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_word5 got=%h exp=deadbeef", (p5 < 0) ? 32'h0 : acc_data[p5]);
    end
  endtask

  task automatic test_random();
    int base_n, base_d, n;
    bit ok;
    for (int k = 1; k < 32; k++) begin
      ref_mem[k] = $urandom;
      we = 1'b1; writeaddr = AW'(k); writedata = ref_mem[k];
      step();
    end
    we = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < int'($urandom_range(1, 5)); g++) step();
      base_n = acc_idx.size(); base_d = done_cnt;
      pulse_start();
      wait_done(base_d, 1'b1, ok);
      step();
      n = acc_idx.size() - base_n;
      checks++; if (!ok || n != 32) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=32", r, n); end
      for (int i = 0; i < n && i < 32; i++) begin
        checks++; if (acc_idx[base_n+i] != i || acc_data[base_n+i] !== ref_mem[i]) begin
          failures++; $display("FAIL rand_word[%0d][%0d] got=%0d:%h exp=%0d:%h", r, i, acc_idx[base_n+i], acc_data[base_n+i], i, ref_mem[i]);
        end
      end
    end
  endtask

  initial begin
    bus.out_ready  = 1'b1;
    bus6.out_ready = 1'b1;
    test_reset();
    preload();
    test_full_dump();
    test_backpressure();
    test_mid_start();
    test_reset_mid();
    test_single_reg();
    test_bypass();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
